// File: rtl/usb_pkg.sv
// Shared constants and verdict helper for the USB receive-side packet checker.
package usb_pkg;

  localparam logic [1:0] CLS_SPECIAL = 2'b00;
  localparam logic [1:0] CLS_TOKEN   = 2'b01;
  localparam logic [1:0] CLS_HSHAKE  = 2'b10;
  localparam logic [1:0] CLS_DATA    = 2'b11;

  localparam logic [4:0]  CRC5_INIT   = 5'h1F;
  localparam logic [4:0]  CRC5_POLY   = 5'h14;
  localparam logic [4:0]  CRC5_RESID  = 5'h06;
  localparam logic [15:0] CRC16_INIT  = 16'hFFFF;
  localparam logic [15:0] CRC16_POLY  = 16'hA001;
  localparam logic [15:0] CRC16_RESID = 16'hB001;

  typedef enum logic [1:0] {ERR_NONE, ERR_PID, ERR_LEN, ERR_CRC} err_e;

  // Priority pid > len > crc; len is the body byte count after the PID.
  function automatic err_e pkt_verdict(input logic        pid_ok,
                                       input logic [1:0]  cls,
                                       input logic [10:0] len,
                                       input logic [4:0]  crc5,
                                       input logic [15:0] crc16,
                                       input logic [10:0] max_len);
    err_e e;
    e = ERR_NONE;
    if (!pid_ok) e = ERR_PID;
    else begin
      case (cls)
        CLS_TOKEN:  if (len != 11'd2) e = ERR_LEN;
                    else if (crc5 != CRC5_RESID) e = ERR_CRC;
        CLS_DATA:   if (len < 11'd2 || len > max_len) e = ERR_LEN;
                    else if (crc16 != CRC16_RESID) e = ERR_CRC;
        CLS_HSHAKE: if (len != 11'd0) e = ERR_LEN;
        default:    e = ERR_NONE;
      endcase
    end
    return e;
  endfunction

endpackage

// File: rtl/usb_pkt_check_if.sv
// Byte-wide stream handshake used on both sides of the packet checker.
interface axi_stream_iface #(parameter int W = 8);
  logic [W-1:0] tdata;
  logic         tvalid;
  logic         tready;
  logic         tlast;

  modport master (output tdata, tvalid, tlast, input tready);
  modport slave  (input tdata, tvalid, tlast, output tready);
endinterface

// File: rtl/usb_crc_byte.sv
// Combinational one-byte reflected CRC update, bit 0 first; init selects the seed.
module usb_crc_byte #(
  parameter int           W    = 16,
  parameter logic [W-1:0] POLY = '0,
  parameter logic [W-1:0] INIT = '1
) (
  input  logic         init,
  input  logic [W-1:0] crc_in,
  input  logic [7:0]   data,
  output logic [W-1:0] crc_out
);
  logic [W-1:0] c;

  always_comb begin
    c = init ? INIT : crc_in;
    for (int i = 0; i < 8; i++)
      c = {1'b0, c[W-1:1]} ^ (((c[0] ^ data[i]) != 1'b0) ? POLY : '0);
    crc_out = c;
  end
endmodule

// File: rtl/usb_pkt_check.sv
// Forwards received USB packets through one register stage, flagging bad ones on tlast.
module usb_pkt_check
  import usb_pkg::*;
#(
  parameter int MAX_DATA_LEN = 1026,
  parameter int CNT_W        = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  axi_stream_iface.slave    rx,
  axi_stream_iface.master   tx,
  output logic              tx_err,
  input  logic              cnt_clr,
  output logic [CNT_W-1:0]  pid_err_cnt,
  output logic [CNT_W-1:0]  crc_err_cnt,
  output logic [CNT_W-1:0]  len_err_cnt
);
  typedef enum logic {S_PID, S_BODY} state_e;

  state_e      state;
  logic        pid_ok_q, pid_ok_c;
  logic [1:0]  cls_q, cls_c;
  logic [10:0] len_q, len_c;
  logic [4:0]  crc5_q, crc5_nxt, crc5_c;
  logic [15:0] crc16_q, crc16_nxt, crc16_c;
  logic        acc, bad, first_body;
  err_e        err_c;

  assign rx.tready  = !tx.tvalid || tx.tready;
  assign acc        = rx.tvalid && rx.tready;
  // First body byte seeds from the init constant, so no re-init on the PID beat.
  assign first_body = (len_q == 11'd0);

  usb_crc_byte #(.W(5), .POLY(CRC5_POLY), .INIT(CRC5_INIT)) u_crc5 (
    .init(first_body), .crc_in(crc5_q), .data(rx.tdata), .crc_out(crc5_nxt));

  usb_crc_byte #(.W(16), .POLY(CRC16_POLY), .INIT(CRC16_INIT)) u_crc16 (
    .init(first_body), .crc_in(crc16_q), .data(rx.tdata), .crc_out(crc16_nxt));

  always_comb begin
    if (state == S_PID) begin
      pid_ok_c = (rx.tdata[3:0] == ~rx.tdata[7:4]);
      cls_c    = rx.tdata[1:0];
      len_c    = 11'd0;
      crc5_c   = CRC5_INIT;
      crc16_c  = CRC16_INIT;
    end else begin
      pid_ok_c = pid_ok_q;
      cls_c    = cls_q;
      len_c    = (&len_q) ? len_q : len_q + 11'd1;
      crc5_c   = crc5_nxt;
      crc16_c  = crc16_nxt;
    end
    err_c = pkt_verdict(pid_ok_c, cls_c, len_c, crc5_c, crc16_c, 11'(MAX_DATA_LEN));
    bad   = acc && rx.tlast && (err_c != ERR_NONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_PID;
      pid_ok_q <= 1'b0;
      cls_q    <= CLS_SPECIAL;
      len_q    <= '0;
      crc5_q   <= CRC5_INIT;
      crc16_q  <= CRC16_INIT;
    end else if (acc) begin
      if (state == S_PID) begin
        pid_ok_q <= pid_ok_c;
        cls_q    <= cls_c;
        len_q    <= '0;
        state    <= rx.tlast ? S_PID : S_BODY;
      end else begin
        len_q   <= len_c;
        crc5_q  <= crc5_nxt;
        crc16_q <= crc16_nxt;
        if (rx.tlast) state <= S_PID;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx.tvalid <= 1'b0;
      tx.tdata  <= '0;
      tx.tlast  <= 1'b0;
      tx_err    <= 1'b0;
    end else if (rx.tready) begin
      tx.tvalid <= rx.tvalid;
      if (rx.tvalid) begin
        tx.tdata <= rx.tdata;
        tx.tlast <= rx.tlast;
        tx_err   <= bad;
      end
    end
  end

  // Saturating statistics; a clear beats a same-cycle increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pid_err_cnt <= '0;
      crc_err_cnt <= '0;
      len_err_cnt <= '0;
    end else if (cnt_clr) begin
      pid_err_cnt <= '0;
      crc_err_cnt <= '0;
      len_err_cnt <= '0;
    end else if (bad) begin
      case (err_c)
        ERR_PID: if (!(&pid_err_cnt)) pid_err_cnt <= pid_err_cnt + 1'b1;
        ERR_LEN: if (!(&len_err_cnt)) len_err_cnt <= len_err_cnt + 1'b1;
        ERR_CRC: if (!(&crc_err_cnt)) crc_err_cnt <= crc_err_cnt + 1'b1;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_usb_pkt_check.sv
// Directed, table-driven bench for usb_pkt_check.
module tb_usb_pkt_check;
  logic       clk = 1'b0;
  logic       rst_n, cnt_clr, tx_err;
  logic [7:0] pid_cnt, crc_cnt, len_cnt;
  logic       bp_mode;

  always #5 clk = ~clk;

  axi_stream_iface #(.W(8)) rx_if ();
  axi_stream_iface #(.W(8)) tx_if ();

  usb_pkt_check #(.MAX_DATA_LEN(1026), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .rx(rx_if), .tx(tx_if), .tx_err(tx_err),
    .cnt_clr(cnt_clr), .pid_err_cnt(pid_cnt), .crc_err_cnt(crc_cnt),
    .len_err_cnt(len_cnt));

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    end
  endtask

  // Sink ready: always 1, or toggling every cycle under backpressure.
  initial begin
    tx_if.tready = 1'b1;
    forever begin
      @(posedge clk); #1;
      tx_if.tready = bp_mode ? ~tx_if.tready : 1'b1;
    end
  end

  logic [7:0] out_q[$];
  logic       err_q[$];
  logic       last_q[$];

  always @(negedge clk)
    if (rst_n === 1'b1 && tx_if.tvalid === 1'b1 && tx_if.tready === 1'b1) begin
      out_q.push_back(tx_if.tdata);
      err_q.push_back(tx_err);
      last_q.push_back(tx_if.tlast);
    end

  logic       stall_prev = 1'b0;
  logic [7:0] p_data;
  logic       p_last, p_err;

  always @(negedge clk)
    if (bp_mode) begin
      if (stall_prev) begin
        chk("hold_valid", tx_if.tvalid, 1'b1);
        chk("hold_data", {tx_if.tdata, tx_if.tlast, tx_err}, {p_data, p_last, p_err});
      end
      chk("rx_tready", rx_if.tready, !tx_if.tvalid || tx_if.tready);
      stall_prev = tx_if.tvalid && !tx_if.tready;
      p_data = tx_if.tdata;
      p_last = tx_if.tlast;
      p_err  = tx_err;
    end else stall_prev = 1'b0;

  logic [7:0] pkt_buf [0:1100];

  task automatic send_buf(input int n, input bit with_last);
    for (int i = 0; i < n; i++) begin
      int t;
      rx_if.tvalid = 1'b1;
      rx_if.tdata  = pkt_buf[i];
      rx_if.tlast  = with_last && (i == n - 1);
      t = 0;
      do begin @(negedge clk); t++; end while (rx_if.tready !== 1'b1 && t < 64);
      if (rx_if.tready !== 1'b1) chk("rx_accept_timeout", 0, 1);
      @(posedge clk); #1;
    end
    rx_if.tvalid = 1'b0;
    rx_if.tlast  = 1'b0;
  endtask

  task automatic drain(input int n);
    int t = 0;
    while (out_q.size() < n && t < 200) begin
      @(posedge clk); #2; t++;
    end
  endtask

  task automatic clear_q();
    out_q.delete(); err_q.delete(); last_q.delete();
  endtask

  task automatic check_pkt(input string nm, input int n, input logic exp_err);
    int bad = 0, mid = 0;
    drain(n);
    chk({nm, "_nbeats"}, out_q.size(), n);
    for (int i = 0; i < out_q.size(); i++) begin
      if (i < n && out_q[i] !== pkt_buf[i]) bad++;
      if (i < n - 1 && (err_q[i] !== 1'b0 || last_q[i] !== 1'b0)) mid++;
    end
    chk({nm, "_bytes"}, bad, 0);
    chk({nm, "_mid_flags"}, mid, 0);
    if (out_q.size() == n)
      chk({nm, "_last_err"}, {last_q[n-1], err_q[n-1]}, {1'b1, exp_err});
    clear_q();
  endtask

  task automatic chk_cnt(input string nm, input int p, input int c, input int l);
    chk({nm, "_pid_cnt"}, pid_cnt, p);
    chk({nm, "_crc_cnt"}, crc_cnt, c);
    chk({nm, "_len_cnt"}, len_cnt, l);
  endtask

  function automatic logic [15:0] crc16_tx(input int first, input int last);
    logic [15:0] c = 16'hFFFF;
    for (int i = first; i <= last; i++)
      for (int k = 0; k < 8; k++)
        if ((c[0] ^ pkt_buf[i][k]) == 1'b1) c = (c >> 1) ^ 16'hA001;
        else c = c >> 1;
    return ~c;
  endfunction

  typedef struct {
    string       name;
    int          n;
    logic [95:0] b;
    logic        err;
    int          p, c, l;
  } vec_t;

  vec_t vecs[15];

  task automatic setv(input int i, input string nm, input int n, input logic [95:0] b,
                      input logic e, input int p, input int c, input int l);
    vecs[i].name = nm; vecs[i].n = n; vecs[i].b = b; vecs[i].err = e;
    vecs[i].p = p; vecs[i].c = c; vecs[i].l = l;
  endtask

  initial begin
    logic [15:0] crc;
    setv(0,  "out_tok",   3,  {24'hE10010, 72'h0},               1'b0, 0, 0, 0);
    setv(1,  "data0_ok",  11, {88'hC3_80_06_00_01_00_00_40_00_DD_94, 8'h0}, 1'b0, 0, 0, 0);
    setv(2,  "data0_crc", 11, {88'hC3_80_06_00_01_00_00_40_00_DD_95, 8'h0}, 1'b1, 0, 1, 0);
    setv(3,  "bad_pid",   3,  {24'hE20010, 72'h0},               1'b1, 1, 1, 0);
    setv(4,  "ack",       1,  {8'hD2, 88'h0},                    1'b0, 1, 1, 0);
    setv(5,  "ack_long",  2,  {16'hD200, 80'h0},                 1'b1, 1, 1, 1);
    setv(6,  "setup",     3,  {24'h2D0010, 72'h0},               1'b0, 1, 1, 1);
    setv(7,  "tok_crc",   3,  {24'hE10011, 72'h0},               1'b1, 1, 2, 1);
    setv(8,  "tok_long",  4,  {32'hE1001000, 64'h0},             1'b1, 1, 2, 2);
    setv(9,  "data1_min", 3,  {24'h4B0000, 72'h0},               1'b0, 1, 2, 2);
    setv(10, "data_pid",  1,  {8'hC3, 88'h0},                    1'b1, 1, 2, 3);
    setv(11, "data_1b",   2,  {16'hC300, 80'h0},                 1'b1, 1, 2, 4);
    setv(12, "special",   3,  {24'h3C1234, 72'h0},               1'b0, 1, 2, 4);
    setv(13, "nak",       1,  {8'h5A, 88'h0},                    1'b0, 1, 2, 4);
    setv(14, "pid_only",  1,  {8'h00, 88'h0},                    1'b1, 2, 2, 4);

    rst_n = 1'b0; cnt_clr = 1'b0; bp_mode = 1'b0;
    rx_if.tvalid = 1'b0; rx_if.tdata = 8'h00; rx_if.tlast = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_tx", {tx_if.tvalid, tx_if.tlast, tx_err, tx_if.tdata}, 11'h0);
    chk_cnt("rst", 0, 0, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // One-cycle latency on a lone ACK.
    rx_if.tvalid = 1'b1; rx_if.tdata = 8'hD2; rx_if.tlast = 1'b1;
    @(posedge clk); #1;
    rx_if.tvalid = 1'b0; rx_if.tlast = 1'b0;
    chk("lat_beat", {tx_if.tvalid, tx_if.tdata, tx_if.tlast, tx_err}, {1'b1, 8'hD2, 1'b1, 1'b0});
    @(posedge clk); #1;
    chk("lat_idle", tx_if.tvalid, 1'b0);
    clear_q();

    for (int i = 0; i < 15; i++) begin
      for (int j = 0; j < vecs[i].n; j++) pkt_buf[j] = vecs[i].b[95 - 8*j -: 8];
      send_buf(vecs[i].n, 1'b1);
      check_pkt(vecs[i].name, vecs[i].n, vecs[i].err);
      chk_cnt(vecs[i].name, vecs[i].p, vecs[i].c, vecs[i].l);
    end

    // Maximum-length data packet: 1024 payload + valid CRC is clean.
    pkt_buf[0] = 8'hC3;
    for (int i = 1; i <= 1024; i++) pkt_buf[i] = 8'(i * 7);
    crc = crc16_tx(1, 1024);
    pkt_buf[1025] = crc[7:0]; pkt_buf[1026] = crc[15:8];
    send_buf(1027, 1'b1);
    check_pkt("data_max", 1027, 1'b0);
    chk_cnt("data_max", 2, 2, 4);

    // One byte over the limit with a valid CRC: length error only.
    for (int i = 1; i <= 1025; i++) pkt_buf[i] = 8'(i * 7);
    crc = crc16_tx(1, 1025);
    pkt_buf[1026] = crc[7:0]; pkt_buf[1027] = crc[15:8];
    send_buf(1028, 1'b1);
    check_pkt("data_over", 1028, 1'b1);
    chk_cnt("data_over", 2, 2, 5);

    // Backpressure on the clean DATA0 packet.
    for (int j = 0; j < 11; j++) pkt_buf[j] = vecs[1].b[95 - 8*j -: 8];
    bp_mode = 1'b1;
    send_buf(11, 1'b1);
    drain(11);
    bp_mode = 1'b0;
    check_pkt("bp_data0", 11, 1'b0);
    chk_cnt("bp_data0", 2, 2, 5);

    // Saturation then clear racing a bad tlast.
    pkt_buf[0] = 8'h00;
    for (int i = 0; i < 300; i++) send_buf(1, 1'b1);
    drain(300);
    clear_q();
    chk_cnt("sat", 255, 2, 5);
    cnt_clr = 1'b1;
    send_buf(1, 1'b1);
    cnt_clr = 1'b0;
    drain(1);
    clear_q();
    chk_cnt("clr_race", 0, 0, 0);

    // Reset mid-packet, then a clean SETUP.
    for (int j = 0; j < 5; j++) pkt_buf[j] = vecs[1].b[95 - 8*j -: 8];
    send_buf(5, 1'b0);
    chk("rst_pre_valid", tx_if.tvalid, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("rst_drop", {tx_if.tvalid, tx_if.tlast}, 2'b00);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    clear_q();
    pkt_buf[0] = 8'h2D; pkt_buf[1] = 8'h00; pkt_buf[2] = 8'h10;
    send_buf(3, 1'b1);
    check_pkt("post_rst_setup", 3, 1'b0);
    chk_cnt("post_rst", 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
